tick_sched: RTL and testbench



---
 rtl/tick_sched_pkg.sv | 19 +
 rtl/tick_div.sv | 32 +++
 rtl/tick_sched.sv | 141 ++++++++++++++
 tb/tb_tick_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared register map, CTRL bit positions and FSM encoding for the tick scheduler.
package tick_sched_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_CMP    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_div.sv
// Reference-tick divider: counts 0..div_act and pulses at the terminal count.
module tick_div #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [BW-1:0] reload,
  output logic          tick
);

  logic [BW-1:0] cnt;
  logic [BW-1:0] div_act;

  assign tick = en && (cnt == div_act);

  // The active ratio is only reloaded on clr or at a terminal count, so a
  // period in flight is never truncated or stretched by a DIV rewrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_act <= '0;
    end else if (clr || tick) begin
      cnt     <= '0;
      div_act <= reload;
    end else if (en) begin
      cnt <= cnt + BW'(1);
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Tick scheduler: register file, run/one-shot FSM and tick-vs-compare event counter
// around a tick_div instance.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int BW = 8,
  parameter int CW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        tick_out,
  output logic        irq,
  output logic        busy
);

  state_t        state;
  logic [2:0]    ctrl;
  logic [BW-1:0] div_reg;
  logic [CW-1:0] cmp_reg;
  logic [CW-1:0] tick_cnt;
  logic          pending;

  logic          ctrl_wr;
  logic          start;
  logic          stop;
  logic          tick;
  logic          div_en;
  logic          evt;
  logic          oneshot_end;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   cmp_eff;
  logic          unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  assign ctrl_wr = cfg_we && (cfg_addr == ADDR_CTRL);
  assign start   = ctrl_wr && cfg_wdata[CTRL_EN] && (state != ST_RUN);
  assign stop    = ctrl_wr && !cfg_wdata[CTRL_EN];
  assign div_en  = (state == ST_RUN);

  // CMP of 0 behaves as 1 so every tick is an event rather than never firing.
  assign cnt_inc     = {1'b0, tick_cnt} + (CW+1)'(1);
  assign cmp_eff     = (cmp_reg == '0) ? (CW+1)'(1) : {1'b0, cmp_reg};
  assign evt         = tick && (cnt_inc >= cmp_eff);
  assign oneshot_end = evt && !ctrl[CTRL_PERIODIC] && !stop;

  tick_div #(.BW(BW)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (div_en),
    .clr    (start || stop),
    .reload (div_reg),
    .tick   (tick)
  );

  assign tick_out = tick;
  assign irq      = pending && ctrl[CTRL_IRQ_EN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      ctrl     <= '0;
      div_reg  <= '0;
      cmp_reg  <= '0;
      tick_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_CTRL: ctrl    <= cfg_wdata[2:0];
          ADDR_DIV:  div_reg <= cfg_wdata[BW-1:0];
          ADDR_CMP:  cmp_reg <= cfg_wdata[CW-1:0];
          default:   ;
        endcase
      end
      if (oneshot_end)
        ctrl[CTRL_EN] <= 1'b0;

      // A new event outranks a simultaneous W1C so no interrupt is lost.
      if (evt)
        pending <= 1'b1;
      else if (cfg_we && (cfg_addr == ADDR_STATUS) && cfg_wdata[0])
        pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            tick_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end else if (evt) begin
            tick_cnt <= '0;
            if (oneshot_end) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
          end else if (tick) begin
            tick_cnt <= cnt_inc[CW-1:0];
          end
        end
        ST_DONE: begin
          if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            tick_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:   cfg_rdata = 32'(ctrl);
      ADDR_DIV:    cfg_rdata = 32'(div_reg);
      ADDR_CMP:    cfg_rdata = 32'(cmp_reg);
      ADDR_STATUS: cfg_rdata = 32'({tick_cnt, pending});
      default:     cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: per-cycle tick/irq/busy expectations are queued
// with each stimulus step and popped as the DUT runs; register reads checked directly.
module tb_tick_sched;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        tick_out;
  logic        irq;
  logic        busy;

  typedef struct packed {
    logic tick;
    logic irq;
    logic busy;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [1:0] A_CTRL = 2'd0, A_DIV = 2'd1, A_CMP = 2'd2, A_STATUS = 2'd3;

  tick_sched #(.BW(8), .CW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .tick_out  (tick_out),
    .irq       (irq),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic t, input logic i, input logic b);
    exp_t e;
    e.tick = t;
    e.irq  = i;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, e);
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tick_out", tick_out, e.tick);
        chk("irq", irq, e.irq);
        chk("busy", busy, e.busy);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = A_CTRL;
    cfg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    rd(A_CTRL, 0, "rst_ctrl");
    rd(A_DIV, 0, "rst_div");
    rd(A_CMP, 0, "rst_cmp");
    rd(A_STATUS, 0, "rst_status");
    for (int k = 0; k < 20; k++) push(1'b0, 1'b0, 1'b0);
    run_cycles(20);

    // Periodic, DIV=3, CMP=2, irq enabled
    wr(A_DIV, 3);
    wr(A_CMP, 2);
    for (int k = 0; k < 12; k++) push((k % 4) == 3, k >= 8, 1'b1);
    wr(A_CTRL, 32'h7);
    run_cycles(12);
    for (int k = 13; k < 17; k++) push((k % 4) == 3, k == 16, 1'b1);
    wr(A_STATUS, 1);
    run_cycles(4);
    rd(A_STATUS, 1, "per_status");
    rd(A_CTRL, 7, "per_ctrl");
    wr(A_CTRL, 0);
    wr(A_STATUS, 1);

    // One-shot, DIV=0, CMP=5
    wr(A_DIV, 0);
    wr(A_CMP, 5);
    for (int k = 0; k < 7; k++) push(k < 5, 1'b0, k < 5);
    wr(A_CTRL, 32'h1);
    run_cycles(7);
    rd(A_CTRL, 0, "os_ctrl_en_clr");
    rd(A_STATUS, 1, "os_pending");
    wr(A_STATUS, 1);
    rd(A_STATUS, 0, "os_w1c");

    // Ratio change mid-period: DIV 9 -> 1 written in cycle 3
    wr(A_DIV, 9);
    wr(A_CMP, 100);
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b1);
    wr(A_CTRL, 32'h3);
    run_cycles(3);
    for (int k = 4; k < 16; k++) push(k == 9 || k == 11 || k == 13 || k == 15, 1'b0, 1'b1);
    wr(A_DIV, 1);
    run_cycles(12);
    wr(A_CTRL, 0);

    // Event coinciding with W1C
    wr(A_DIV, 3);
    wr(A_CMP, 1);
    for (int k = 0; k < 7; k++) push(k == 3, 1'b0, 1'b1);
    wr(A_CTRL, 32'h3);
    run_cycles(7);
    wr(A_STATUS, 1);
    rd(A_STATUS, 1, "evt_beats_w1c");
    wr(A_STATUS, 1);
    rd(A_STATUS, 0, "w1c_plain");
    wr(A_CTRL, 0);

    // Stop mid-period
    wr(A_CMP, 10);
    for (int k = 0; k < 6; k++) push(k == 3, 1'b0, 1'b1);
    wr(A_CTRL, 32'h3);
    run_cycles(6);
    rd(A_STATUS, 2, "tick_cnt_one");
    wr(A_CTRL, 0);
    for (int k = 0; k < 12; k++) push(1'b0, 1'b0, 1'b0);
    run_cycles(12);
    rd(A_STATUS, 0, "stop_status");

    // Asynchronous reset mid-run
    wr(A_DIV, 0);
    wr(A_CMP, 3);
    for (int k = 0; k < 5; k++) push(1'b1, k >= 3, 1'b1);
    wr(A_CTRL, 32'h7);
    run_cycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", tick_out, 0);
    chk("arst_irq", irq, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) push(1'b0, 1'b0, 1'b0);
    run_cycles(10);
    rd(A_CTRL, 0, "arst_ctrl");
    rd(A_DIV, 0, "arst_div");
    rd(A_CMP, 0, "arst_cmp");
    rd(A_STATUS, 0, "arst_status");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
